pattern_tx: RTL and testbench
=============================

Name: pattern_tx

Overview:
- Serial pattern transmitter: captures a WIDTH-bit pattern on a start request and shifts it out MSB-first, one bit per clock, repeated a programmable number of times.
- Produces the bit stream consumed by the Mealy 1101 sequence detector ("mealy"). It is the stimulus source for that detector in lab and system integration.
- Reports progress with busy/done status and supports abort mid-stream.

Parameters:
- WIDTH, 4, pattern length in bits (>=2)
- CNT_W, 4, width of repeat count input
- IDLE_VAL, 1'b0, value driven on o when not transmitting

Ports:
- clk  input  1  system clock, rising-edge active
- n_rst  input  1  asynchronous active-low reset
- start  input  1  transmit request, sampled on rising edge
- pattern  input  WIDTH  pattern to send, MSB first; captured when start is accepted
- repeat_cnt  input  CNT_W  number of back-to-back pattern transmissions; captured when start is accepted; 0 treated as 1
- abort  input  1  terminate transmission at next edge
- o  output  1  registered serial data out
- busy  output  1  high while pattern bits are on o
- done  output  1  one-cycle pulse after final bit of final repetition

Behaviour:
- Clock/reset: one clock (clk); reset is asynchronous, active-low (n_rst). On reset assertion, immediately: state=IDLE, o=IDLE_VAL, busy=0, done=0, shift register, bit counter and repeat counter = 0.
- All outputs are registered; no combinational path from any input to any output.
- States:
  - IDLE
  - SHIFT
  - DONE
- IDLE: o=IDLE_VAL, busy=0, done=0.
  - start=1 and abort=0 at edge k: latch pattern and repeat_cnt (0→1), bit index=WIDTH-1, go to SHIFT.
  - Cycle after edge k: o=pattern[WIDTH-1], busy=1. First bit appears 1 cycle after the start edge.
- SHIFT: each edge advances one bit, MSB to LSB. Each bit is held exactly one clock period.
  - After bit 0 of a repetition with repetitions remaining: the next cycle carries the captured pattern's MSB again. There is no gap between repetitions.
  - After bit 0 of the final repetition: go to DONE.
- DONE: lasts one cycle. done=1, busy=0, o=IDLE_VAL.
  - start=1 (abort=0) at the edge leaving DONE is accepted exactly as in IDLE, giving back-to-back jobs with a one-cycle idle gap.
  - Otherwise return to IDLE.
- start while in SHIFT: ignored, not queued. Changes to pattern/repeat_cnt during SHIFT have no effect.
- abort=1 at any edge in SHIFT or DONE: next state IDLE, o=IDLE_VAL, busy=0, done=0. No done pulse is produced.
- abort and start at the same edge: abort wins, start is dropped.
- Total busy length = WIDTH × max(repeat_cnt,1) cycles.
- Repeat counter must not wrap: repeat_cnt = 2^CNT_W−1 sends exactly that many repetitions.
- Reset asserted mid-transmission: outputs return to reset values asynchronously. After release the block sits in IDLE until a new start.

Optional Feature:
- Macro: PATTERN_TX_LAST_EN
- Defined: adds output port last (1 bit, registered, reset 0). last=1 during the cycle carrying bit 0 of every repetition and 0 otherwise. This aligns with the cycle on which the Mealy detector asserts its output for a matching pattern.
- Undefined: port last does not exist. No associated logic.

Test Plan:
- Reset: n_rst=0 with start=1, pattern=4'b1101 → o=0, busy=0, done=0 throughout reset. After release on a negedge, outputs stay idle until a new start edge.
- Single send: pattern=4'b1101, repeat_cnt=1, start pulsed one cycle → o = 1,1,0,1 on cycles 1–4 after the start edge, busy=1 for those 4 cycles. Cycle 5: done=1, o=0. Cycle 6: done=0. Chained into mealy, the detector o=1 exactly on cycle 4.
- Repeat: pattern=4'b1101, repeat_cnt=2 → o = 1,1,0,1,1,1,0,1 contiguous, busy=1 for 8 cycles, single done pulse on cycle 9. repeat_cnt=0 behaves identically to repeat_cnt=1.
- Abort: pattern=4'b1111, repeat_cnt=3, abort pulsed at the 6th edge after start → o returns to 0 and busy to 0 the following cycle, done never asserts. Same-edge start+abort from IDLE → remains IDLE.
- Start while busy / back-to-back: second start during SHIFT with pattern=4'b0000 → ignored, stream stays 1101. Start asserted during the DONE cycle with pattern=4'b1010 → o = 1,0,1,0 beginning the next cycle.
- With PATTERN_TX_LAST_EN: pattern=4'b1100, repeat_cnt=2 → last=1 only on cycles 4 and 8 after the start edge.

Source files
------------

// File: rtl/pattern_tx.sv
// Serial pattern transmitter: sends a captured WIDTH-bit pattern MSB-first, repeated N times.
// Optional `last` marker on bit 0 of each repetition is enabled by defining PATTERN_TX_LAST_EN.
module pattern_tx #(
  parameter int   WIDTH    = 4,
  parameter int   CNT_W    = 4,
  parameter logic IDLE_VAL = 1'b0
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic [WIDTH-1:0] pattern,
  input  logic [CNT_W-1:0] repeat_cnt,
  input  logic             abort,
  output logic             o,
  output logic             busy,
  output logic             done
`ifdef PATTERN_TX_LAST_EN
  ,
  output logic             last
`endif
);

  localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [BIT_W-1:0] BIT_MSB  = BIT_W'(WIDTH - 1);
  localparam logic [BIT_W-1:0] BIT_ZERO = '0;
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [CNT_W-1:0] REP_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] pat_q;
  logic [BIT_W-1:0] bit_q;
  logic [CNT_W-1:0] rep_q;
  logic             o_q;
  logic             busy_q;
  logic             done_q;
`ifdef PATTERN_TX_LAST_EN
  logic             last_q;
`endif

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      pat_q   <= '0;
      bit_q   <= '0;
      rep_q   <= '0;
      o_q     <= IDLE_VAL;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PATTERN_TX_LAST_EN
      last_q  <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
`ifdef PATTERN_TX_LAST_EN
      last_q <= 1'b0;
`endif
      case (state_q)
        // DONE accepts a new job exactly like IDLE, giving a one-cycle gap between jobs.
        IDLE, DONE: begin
          if (start && !abort) begin
            state_q <= SHIFT;
            pat_q   <= pattern;
            bit_q   <= BIT_MSB;
            rep_q   <= (repeat_cnt == '0) ? REP_ONE : repeat_cnt;
            o_q     <= pattern[WIDTH-1];
            busy_q  <= 1'b1;
          end else begin
            state_q <= IDLE;
            o_q     <= IDLE_VAL;
            busy_q  <= 1'b0;
          end
        end
        SHIFT: begin
          if (abort) begin
            state_q <= IDLE;
            o_q     <= IDLE_VAL;
            busy_q  <= 1'b0;
          end else if (bit_q == BIT_ZERO) begin
            if (rep_q <= REP_ONE) begin
              state_q <= DONE;
              o_q     <= IDLE_VAL;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              // Count down remaining repetitions; never wraps since we stop at one.
              rep_q <= rep_q - REP_ONE;
              bit_q <= BIT_MSB;
              o_q   <= pat_q[WIDTH-1];
            end
          end else begin
            bit_q <= bit_q - BIT_ONE;
            o_q   <= pat_q[bit_q - BIT_ONE];
`ifdef PATTERN_TX_LAST_EN
            last_q <= (bit_q == BIT_ONE);
`endif
          end
        end
        default: begin
          state_q <= IDLE;
          o_q     <= IDLE_VAL;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o    = o_q;
  assign busy = busy_q;
  assign done = done_q;
`ifdef PATTERN_TX_LAST_EN
  assign last = last_q;
`endif

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx: inputs driven on negedge, outputs sampled on negedge.
module tb_pattern_tx;
  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [3:0] pattern = 4'b0000;
  logic [3:0] repeat_cnt = 4'd0;
  logic       o, busy, done;
`ifdef PATTERN_TX_LAST_EN
  logic       last;
`endif

  int checks = 0;
  int failures = 0;
  logic [3:0] exp4;
  logic [7:0] exp8;

  always #5 clk = ~clk;

  pattern_tx #(.WIDTH(4), .CNT_W(4), .IDLE_VAL(1'b0)) dut (
    .clk        (clk),
    .n_rst      (n_rst),
    .start      (start),
    .pattern    (pattern),
    .repeat_cnt (repeat_cnt),
    .abort      (abort),
    .o          (o),
    .busy       (busy),
    .done       (done)
`ifdef PATTERN_TX_LAST_EN
    ,
    .last       (last)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic eo, input logic eb, input logic ed);
    chk({tag, ".o"}, {31'd0, o}, {31'd0, eo});
    chk({tag, ".busy"}, {31'd0, busy}, {31'd0, eb});
    chk({tag, ".done"}, {31'd0, done}, {31'd0, ed});
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // Reset held with start asserted
    @(negedge clk);
    start = 1'b1; pattern = 4'b1101; repeat_cnt = 4'd1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_out("reset", 1'b0, 1'b0, 1'b0);
`ifdef PATTERN_TX_LAST_EN
      chk("reset.last", {31'd0, last}, 32'd0);
`endif
    end
    start = 1'b0;
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_out("post_reset_idle", 1'b0, 1'b0, 1'b0);
    end

    // Single send 1101
    exp4 = 4'b1101;
    pattern = 4'b1101; repeat_cnt = 4'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_out("single_bit", exp4[3-i], 1'b1, 1'b0);
      cyc();
    end
    chk_out("single_done", 1'b0, 1'b0, 1'b1);
    cyc();
    chk_out("single_after", 1'b0, 1'b0, 1'b0);

    // Repeat x2 with a start (pattern 0000) attempted mid-stream
    exp8 = 8'b1101_1101;
    pattern = 4'b1101; repeat_cnt = 4'd2; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      chk_out("rep2_bit", exp8[7-i], 1'b1, 1'b0);
      if (i == 1) begin start = 1'b1; pattern = 4'b0000; repeat_cnt = 4'd0; end
      if (i == 2) start = 1'b0;
      cyc();
    end
    chk_out("rep2_done", 1'b0, 1'b0, 1'b1);
    cyc();
    chk_out("rep2_after", 1'b0, 1'b0, 1'b0);

    // repeat_cnt=0 acts as 1, then back-to-back start during DONE
    pattern = 4'b1101; repeat_cnt = 4'd0; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk_out("rep0_bit", exp4[3-i], 1'b1, 1'b0);
      cyc();
    end
    chk_out("rep0_done", 1'b0, 1'b0, 1'b1);
    pattern = 4'b1010; repeat_cnt = 4'd1; start = 1'b1;
    cyc();
    start = 1'b0;
    exp4 = 4'b1010;
    for (int i = 0; i < 4; i++) begin
      chk_out("b2b_bit", exp4[3-i], 1'b1, 1'b0);
      cyc();
    end
    chk_out("b2b_done", 1'b0, 1'b0, 1'b1);
    cyc();
    chk_out("b2b_after", 1'b0, 1'b0, 1'b0);

    // Abort at the 6th edge after start
    pattern = 4'b1111; repeat_cnt = 4'd3; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      chk_out("abort_pre", 1'b1, 1'b1, 1'b0);
      if (i == 6) abort = 1'b1;
      cyc();
    end
    abort = 1'b0;
    for (int i = 0; i < 12; i++) begin
      chk_out("abort_post", 1'b0, 1'b0, 1'b0);
      cyc();
    end

    // Same-edge start+abort from IDLE
    pattern = 4'b1101; repeat_cnt = 4'd1; start = 1'b1; abort = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk_out("start_abort", 1'b0, 1'b0, 1'b0);
      cyc();
    end

    // Maximum repeat count must not wrap: 15 x 4 bits
    exp4 = 4'b1001;
    pattern = 4'b1001; repeat_cnt = 4'd15; start = 1'b1;
    cyc();
    start = 1'b0; pattern = 4'b0110; repeat_cnt = 4'd1;
    for (int i = 0; i < 60; i++) begin
      chk_out("max_rep_bit", exp4[3-(i%4)], 1'b1, 1'b0);
      cyc();
    end
    chk_out("max_rep_done", 1'b0, 1'b0, 1'b1);
    cyc();

    // Asynchronous reset mid-transmission
    pattern = 4'b1101; repeat_cnt = 4'd3; start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk_out("mid_busy", 1'b1, 1'b1, 1'b0);
    #2 n_rst = 1'b0;
    #1 chk_out("async_reset", 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk_out("reset_held", 1'b0, 1'b0, 1'b0);
    n_rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_out("reset_release_idle", 1'b0, 1'b0, 1'b0);
    end

`ifdef PATTERN_TX_LAST_EN
    // last marks bit 0 of each repetition
    exp8 = 8'b1100_1100;
    pattern = 4'b1100; repeat_cnt = 4'd2; start = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      chk("last_flag", {31'd0, last}, {31'd0, (i == 4 || i == 8)});
      chk("last_o", {31'd0, o}, {31'd0, exp8[8-i]});
      cyc();
    end
    chk("last_done", {31'd0, last}, 32'd0);
    chk_out("last_done_out", 1'b0, 1'b0, 1'b1);
    cyc();
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
